// File: rtl/branch_chkpt_table_pkg.sv
// Shared sizing, entry layout and helpers for the branch checkpoint table.
// The table geometry is set here once and picked up by the interface, the CAM and the top.
package branch_chkpt_table_pkg;

  localparam int unsigned NUM_CHKPT   = 4;
  localparam int unsigned ROB_TAG_W   = 5;
  localparam int unsigned PC_W        = 32;
  localparam int unsigned PRF_SIZE    = 128;
  localparam int unsigned PAYLOAD_W   = 64;

  localparam int unsigned CHKPT_IDX_W = $clog2(NUM_CHKPT);
  // Extra MSB is the wrap bit that separates full from empty.
  localparam int unsigned CHKPT_PTR_W = CHKPT_IDX_W + 1;

  typedef logic [CHKPT_IDX_W-1:0] chkpt_idx_t;
  typedef logic [CHKPT_PTR_W-1:0] chkpt_ptr_t;

  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic [PC_W-1:0]      pc;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [PRF_SIZE-1:0]  rdy;
    logic [PAYLOAD_W-1:0] payload;
  } chkpt_entry_t;

  function automatic chkpt_idx_t onehot_to_idx(input logic [NUM_CHKPT-1:0] onehot);
    chkpt_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_CHKPT; i++) begin
      if (onehot[i]) idx = idx | chkpt_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/branch_chkpt_table_if.sv
// Allocate / resolve / mispredict / restore bundle of the branch checkpoint table.
// master = pipeline side (rename, branch unit), slave = the table itself.
interface branch_chkpt_table_if;
  import branch_chkpt_table_pkg::*;

  logic                   alloc_valid;
  logic [PC_W-1:0]        alloc_pc;
  logic [ROB_TAG_W-1:0]   alloc_rob_tag;
  logic [PRF_SIZE-1:0]    alloc_rdy;
  logic [PAYLOAD_W-1:0]   alloc_payload;
  logic                   alloc_ready;
  logic                   resolve_valid;
  logic [ROB_TAG_W-1:0]   resolve_tag;
  logic                   mispredict;
  logic [ROB_TAG_W-1:0]   mispredict_tag;
  logic                   restore_valid;
  logic [PC_W-1:0]        restore_pc;
  logic [PRF_SIZE-1:0]    restore_rdy;
  logic [PAYLOAD_W-1:0]   restore_payload;
  logic                   restore_miss;
  logic [CHKPT_PTR_W-1:0] count;
  logic                   alloc_overflow;

  modport master (
    output alloc_valid, alloc_pc, alloc_rob_tag, alloc_rdy, alloc_payload,
    output resolve_valid, resolve_tag, mispredict, mispredict_tag,
    input  alloc_ready, restore_valid, restore_pc, restore_rdy, restore_payload,
    input  restore_miss, count, alloc_overflow
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_rob_tag, alloc_rdy, alloc_payload,
    input  resolve_valid, resolve_tag, mispredict, mispredict_tag,
    output alloc_ready, restore_valid, restore_pc, restore_rdy, restore_payload,
    output restore_miss, count, alloc_overflow
  );

endinterface

// File: rtl/branch_chkpt_table_chkpt_cam.sv
// Combinational ROB-tag match over the checkpoint entries; returns hit and one-hot index.
module branch_chkpt_table_chkpt_cam
  import branch_chkpt_table_pkg::*;
(
  input  logic [NUM_CHKPT-1:0][ROB_TAG_W-1:0] tags_i,
  input  logic [NUM_CHKPT-1:0]                search_en_i,
  input  logic [ROB_TAG_W-1:0]                tag_i,
  output logic                                hit_o,
  output logic [NUM_CHKPT-1:0]                onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_CHKPT; i++) begin
      onehot_o[i] = search_en_i[i] && (tags_i[i] == tag_i);
    end
  end

  assign hit_o = |onehot_o;

endmodule

// File: rtl/branch_chkpt_table.sv
// Age-ordered circular checkpoint table: allocate at tail, retire resolved entries at head,
// restore and squash-younger on mispredict. Define CHKPT_PERF_EN for saturating perf counters.
module branch_chkpt_table
  import branch_chkpt_table_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  branch_chkpt_table_if.slave bus
`ifdef CHKPT_PERF_EN
  ,
  output logic [31:0]         perf_allocs,
  output logic [31:0]         perf_restores,
  output logic [31:0]         perf_full_stalls
`endif
);

  chkpt_entry_t [NUM_CHKPT-1:0] entries_q, entries_d;
  chkpt_ptr_t                   head_q, head_d, tail_q, tail_d;
  logic                         overflow_q, overflow_d;
  logic                         restore_valid_q, restore_miss_q;
  logic [PC_W-1:0]              restore_pc_q;
  logic [PRF_SIZE-1:0]          restore_rdy_q;
  logic [PAYLOAD_W-1:0]         restore_payload_q;

  chkpt_idx_t                   head_idx, tail_idx, mp_idx;
  chkpt_ptr_t                   mp_ptr, squash_span;
  logic                         full, alloc_fire, retire_fire;
  logic [NUM_CHKPT-1:0][ROB_TAG_W-1:0] tags;
  logic [NUM_CHKPT-1:0]         res_en, mp_en, res_oh, mp_oh;
  logic                         res_cam_hit, mp_cam_hit, res_hit, mp_hit;

  assign head_idx = head_q[CHKPT_IDX_W-1:0];
  assign tail_idx = tail_q[CHKPT_IDX_W-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[CHKPT_IDX_W] != tail_q[CHKPT_IDX_W]);

  always_comb begin
    tags   = '0;
    res_en = '0;
    mp_en  = '0;
    for (int i = 0; i < NUM_CHKPT; i++) begin
      tags[i]   = entries_q[i].rob_tag;
      mp_en[i]  = entries_q[i].valid;
      res_en[i] = entries_q[i].valid && !entries_q[i].done;
    end
  end

  branch_chkpt_table_chkpt_cam u_res_cam (
    .tags_i      (tags),
    .search_en_i (res_en),
    .tag_i       (bus.resolve_tag),
    .hit_o       (res_cam_hit),
    .onehot_o    (res_oh)
  );

  branch_chkpt_table_chkpt_cam u_mp_cam (
    .tags_i      (tags),
    .search_en_i (mp_en),
    .tag_i       (bus.mispredict_tag),
    .hit_o       (mp_cam_hit),
    .onehot_o    (mp_oh)
  );

  assign res_hit = bus.resolve_valid && res_cam_hit;
  assign mp_hit  = bus.mispredict && mp_cam_hit;
  assign mp_idx  = onehot_to_idx(mp_oh);
  // Rebuild the full pointer of the hit entry so the new tail carries the right wrap bit.
  assign mp_ptr      = head_q + {1'b0, chkpt_idx_t'(mp_idx - head_idx)};
  assign squash_span = tail_q - mp_ptr;

  assign alloc_fire  = bus.alloc_valid && !full && !mp_hit;
  assign retire_fire = entries_q[head_idx].valid && entries_q[head_idx].done &&
                       !(mp_hit && (mp_idx == head_idx));

  always_comb begin
    entries_d  = entries_q;
    head_d     = head_q;
    tail_d     = tail_q;
    overflow_d = overflow_q || (bus.alloc_valid && full && !mp_hit);

    for (int i = 0; i < NUM_CHKPT; i++) begin
      if (res_hit && res_oh[i]) entries_d[i].done = 1'b1;
    end

    if (retire_fire) begin
      entries_d[head_idx].valid = 1'b0;
      entries_d[head_idx].done  = 1'b0;
      head_d                    = head_q + chkpt_ptr_t'(1);
    end

    if (alloc_fire) begin
      entries_d[tail_idx].valid   = 1'b1;
      entries_d[tail_idx].done    = 1'b0;
      entries_d[tail_idx].pc      = bus.alloc_pc;
      entries_d[tail_idx].rob_tag = bus.alloc_rob_tag;
      entries_d[tail_idx].rdy     = bus.alloc_rdy;
      entries_d[tail_idx].payload = bus.alloc_payload;
      tail_d                      = tail_q + chkpt_ptr_t'(1);
    end

    if (mp_hit) begin
      for (int i = 0; i < NUM_CHKPT; i++) begin
        if ({1'b0, chkpt_idx_t'(chkpt_idx_t'(i) - mp_idx)} < squash_span) begin
          entries_d[i].valid = 1'b0;
          entries_d[i].done  = 1'b0;
        end
      end
      tail_d = mp_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entries_q         <= '0;
      head_q            <= '0;
      tail_q            <= '0;
      overflow_q        <= 1'b0;
      restore_valid_q   <= 1'b0;
      restore_miss_q    <= 1'b0;
      restore_pc_q      <= '0;
      restore_rdy_q     <= '0;
      restore_payload_q <= '0;
    end else begin
      entries_q       <= entries_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      overflow_q      <= overflow_d;
      restore_valid_q <= mp_hit;
      restore_miss_q  <= bus.mispredict && !mp_cam_hit;
      if (mp_hit) begin
        restore_pc_q      <= entries_q[mp_idx].pc;
        restore_rdy_q     <= entries_q[mp_idx].rdy;
        restore_payload_q <= entries_q[mp_idx].payload;
      end
    end
  end

  assign bus.alloc_ready     = !full;
  assign bus.count           = tail_q - head_q;
  assign bus.alloc_overflow  = overflow_q;
  assign bus.restore_valid   = restore_valid_q;
  assign bus.restore_miss    = restore_miss_q;
  assign bus.restore_pc      = restore_pc_q;
  assign bus.restore_rdy     = restore_rdy_q;
  assign bus.restore_payload = restore_payload_q;

`ifndef SYNTHESIS
  logic dup_tag;
  always_comb begin
    dup_tag = 1'b0;
    for (int i = 0; i < NUM_CHKPT; i++) begin
      if (entries_q[i].valid && (entries_q[i].rob_tag == bus.alloc_rob_tag)) dup_tag = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && alloc_fire) begin
      assert (!dup_tag)
        else $error("branch_chkpt_table: duplicate live ROB tag %0d", bus.alloc_rob_tag);
    end
  end
`endif

`ifdef CHKPT_PERF_EN
  logic [31:0] perf_allocs_q, perf_restores_q, perf_stalls_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_allocs_q   <= '0;
      perf_restores_q <= '0;
      perf_stalls_q   <= '0;
    end else begin
      if (alloc_fire && (perf_allocs_q != '1)) perf_allocs_q <= perf_allocs_q + 32'd1;
      if (mp_hit && (perf_restores_q != '1)) perf_restores_q <= perf_restores_q + 32'd1;
      if (bus.alloc_valid && full && (perf_stalls_q != '1)) begin
        perf_stalls_q <= perf_stalls_q + 32'd1;
      end
    end
  end

  assign perf_allocs      = perf_allocs_q;
  assign perf_restores    = perf_restores_q;
  assign perf_full_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_branch_chkpt_table.sv
// Scoreboard bench for branch_chkpt_table: queue-based age model, directed cases, then random.
module tb_branch_chkpt_table;
  import branch_chkpt_table_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_chkpt_table_if bus ();

`ifdef CHKPT_PERF_EN
  logic [31:0] perf_allocs, perf_restores, perf_full_stalls;
`endif

  branch_chkpt_table dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef CHKPT_PERF_EN
    ,
    .perf_allocs      (perf_allocs),
    .perf_restores    (perf_restores),
    .perf_full_stalls (perf_full_stalls)
`endif
  );

  typedef logic [ROB_TAG_W-1:0] tag_t;
  typedef struct {
    tag_t                 tag;
    logic [PC_W-1:0]      pc;
    logic [PRF_SIZE-1:0]  rdy;
    logic [PAYLOAD_W-1:0] pay;
    bit                   done;
  } ent_t;
  typedef struct {
    bit                   miss;
    logic [PC_W-1:0]      pc;
    logic [PRF_SIZE-1:0]  rdy;
    logic [PAYLOAD_W-1:0] pay;
  } exp_t;
  typedef struct {
    bit                   rst;
    bit                   av;
    tag_t                 atag;
    logic [PC_W-1:0]      pc;
    logic [PRF_SIZE-1:0]  rdy;
    logic [PAYLOAD_W-1:0] pay;
    bit                   rv;
    tag_t                 rtag;
    bit                   mv;
    tag_t                 mtag;
  } stim_t;

  ent_t live[$];  // live checkpoints, oldest first
  exp_t sb[$];
  bit   ovf_m  = 1'b0;
  bit   chk_en = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_live(input tag_t t);
    foreach (live[i]) if (live[i].tag == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic tag_t fresh_tag();
    tag_t t;
    do t = tag_t'($urandom); while (in_live(t));
    return t;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.av = 0; s.atag = '0; s.pc = '0; s.rdy = '0; s.pay = '0;
    s.rv = 0; s.rtag = '0; s.mv = 0; s.mtag = '0;
    return s;
  endfunction

  function automatic stim_t mk_alloc(input tag_t t);
    stim_t s;
    s = idle();
    s.av = 1; s.atag = t; s.pc = $urandom;
    s.rdy = {$urandom, $urandom, $urandom, $urandom};
    s.pay = {$urandom, $urandom};
    return s;
  endfunction

  // Next state of the table from the rules, applied to the pre-edge contents.
  task automatic model_step(input stim_t s);
    int   h;
    bit   hit, ret, full;
    exp_t e;
    ent_t n;
    if (s.rst) begin
      live.delete();
      sb.delete();
      ovf_m = 0;
      return;
    end
    full = (live.size() == NUM_CHKPT);
    h = -1;
    if (s.mv) foreach (live[i]) if (live[i].tag == s.mtag) h = i;
    hit = (h >= 0);
    ret = (live.size() > 0) && live[0].done && !(hit && h == 0);
    if (s.rv) foreach (live[i]) if (!live[i].done && live[i].tag == s.rtag) live[i].done = 1;
    if (s.mv) begin
      e.miss = !hit; e.pc = '0; e.rdy = '0; e.pay = '0;
      if (hit) begin e.pc = live[h].pc; e.rdy = live[h].rdy; e.pay = live[h].pay; end
      sb.push_back(e);
    end
    if (hit) while (live.size() > h) void'(live.pop_back());
    if (ret) void'(live.pop_front());
    if (s.av && !hit) begin
      if (full) ovf_m = 1;
      else begin
        n.tag = s.atag; n.pc = s.pc; n.rdy = s.rdy; n.pay = s.pay; n.done = 0;
        live.push_back(n);
      end
    end
  endtask

  task automatic tick(input stim_t s);
    reset              = s.rst;
    bus.alloc_valid    = s.av;
    bus.alloc_pc       = s.pc;
    bus.alloc_rob_tag  = s.atag;
    bus.alloc_rdy      = s.rdy;
    bus.alloc_payload  = s.pay;
    bus.resolve_valid  = s.rv;
    bus.resolve_tag    = s.rtag;
    bus.mispredict     = s.mv;
    bus.mispredict_tag = s.mtag;
    @(posedge clk);
    model_step(s);
    #1;
  endtask

  task automatic rst_tick();
    stim_t s;
    s = idle();
    s.rst = 1;
    tick(s);
  endtask

  task automatic fill_3_7_9_12(output logic [PC_W-1:0] pc7, output logic [PRF_SIZE-1:0] rdy7);
    stim_t s;
    tick(mk_alloc(3));
    s = mk_alloc(7); pc7 = s.pc; rdy7 = s.rdy;
    tick(s);
    tick(mk_alloc(9));
    tick(mk_alloc(12));
  endtask

  // Monitor: state checks every cycle, restore pulses popped from the scoreboard.
  initial begin
    exp_t e;
    bit   have;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp("count", 128'(bus.count), 128'(live.size()));
        cmp("alloc_ready", 128'(bus.alloc_ready), 128'(live.size() != NUM_CHKPT));
        cmp("alloc_overflow", 128'(bus.alloc_overflow), 128'(ovf_m));
        have = (sb.size() != 0);
        if (have) e = sb.pop_front();
        cmp("restore_valid", 128'(bus.restore_valid), 128'(have && !e.miss));
        cmp("restore_miss", 128'(bus.restore_miss), 128'(have && e.miss));
        if (have && !e.miss) begin
          cmp("restore_pc", 128'(bus.restore_pc), 128'(e.pc));
          cmp("restore_rdy", 128'(bus.restore_rdy), 128'(e.rdy));
          cmp("restore_payload", 128'(bus.restore_payload), 128'(e.pay));
        end
      end
    end
  end

  initial begin
    stim_t                s;
    logic [PC_W-1:0]      pc7, pc8;
    logic [PRF_SIZE-1:0]  rdy7;
    int                   idx;

    rst_tick();
    rst_tick();
    chk_en = 1;
    cmp("reset_count", 128'(bus.count), 128'(0));
    cmp("reset_ready", 128'(bus.alloc_ready), 128'(1));

    // Fill, then overflow.
    fill_3_7_9_12(pc7, rdy7);
    cmp("count_full", 128'(bus.count), 128'(4));
    cmp("ready_full", 128'(bus.alloc_ready), 128'(0));
    tick(mk_alloc(20));
    cmp("overflow_set", 128'(bus.alloc_overflow), 128'(1));
    cmp("count_after_ovf", 128'(bus.count), 128'(4));

    // Out-of-order resolve, in-order retire.
    s = idle(); s.rv = 1; s.rtag = 7; tick(s);
    cmp("no_retire_after_7", 128'(bus.count), 128'(4));
    s.rtag = 3; tick(s);
    cmp("count_resolve_3", 128'(bus.count), 128'(4));
    tick(idle());
    cmp("retire_3", 128'(bus.count), 128'(3));
    tick(idle());
    cmp("retire_7", 128'(bus.count), 128'(2));

    // Mispredict on tag 7.
    rst_tick();
    fill_3_7_9_12(pc7, rdy7);
    s = idle(); s.mv = 1; s.mtag = 7; tick(s);
    cmp("mp7_valid", 128'(bus.restore_valid), 128'(1));
    cmp("mp7_pc", 128'(bus.restore_pc), 128'(pc7));
    cmp("mp7_rdy", 128'(bus.restore_rdy), 128'(rdy7));
    cmp("mp7_count", 128'(bus.count), 128'(1));

    // Wrap the pointers, then mispredict on the oldest entry.
    rst_tick();
    for (int t = 1; t <= 4; t++) tick(mk_alloc(tag_t'(t)));
    s = idle(); s.rv = 1; s.rtag = 1; tick(s);
    s.rtag = 2; tick(s);
    tick(idle());
    cmp("wrap_count2", 128'(bus.count), 128'(2));
    tick(mk_alloc(5));
    tick(mk_alloc(6));
    cmp("wrap_full", 128'(bus.alloc_ready), 128'(0));
    s = idle(); s.mv = 1; s.mtag = 3; tick(s);
    cmp("wrap_mp_count", 128'(bus.count), 128'(0));
    cmp("wrap_mp_ready", 128'(bus.alloc_ready), 128'(1));
    s = mk_alloc(8); pc8 = s.pc; tick(s);
    cmp("wrap_alloc_count", 128'(bus.count), 128'(1));
    s = idle(); s.mv = 1; s.mtag = 8; tick(s);
    cmp("wrap_alloc_pc", 128'(bus.restore_pc), 128'(pc8));

    // Tag not present.
    s = idle(); s.mv = 1; s.mtag = 20; tick(s);
    cmp("miss_pulse", 128'(bus.restore_miss), 128'(1));
    cmp("miss_no_valid", 128'(bus.restore_valid), 128'(0));
    cmp("miss_count", 128'(bus.count), 128'(0));

    // Alloc + mispredict + resolve in one cycle.
    rst_tick();
    fill_3_7_9_12(pc7, rdy7);
    s = mk_alloc(15); s.rv = 1; s.rtag = 3; s.mv = 1; s.mtag = 9; tick(s);
    cmp("combo_count", 128'(bus.count), 128'(2));
    cmp("combo_no_ovf", 128'(bus.alloc_overflow), 128'(0));
    tick(idle());
    cmp("combo_retire", 128'(bus.count), 128'(1));

    // Random traffic against the model.
    rst_tick();
    for (int c = 0; c < 3000; c++) begin
      s = ($urandom_range(0, 1) != 0) ? mk_alloc(fresh_tag()) : idle();
      if ($urandom_range(0, 299) == 0) s.rst = 1;
      if ($urandom_range(0, 2) != 0) begin
        s.rv = 1;
        s.rtag = tag_t'($urandom);
        if (live.size() > 0 && $urandom_range(0, 3) != 0) begin
          idx = int'($urandom_range(0, live.size() - 1));
          s.rtag = live[idx].tag;
        end
      end
      if ($urandom_range(0, 9) == 0) begin
        s.mv = 1;
        s.mtag = tag_t'($urandom);
        if (live.size() > 0 && $urandom_range(0, 3) != 0) begin
          idx = int'($urandom_range(0, live.size() - 1));
          s.mtag = live[idx].tag;
        end
      end
      tick(s);
    end
    tick(idle());
    tick(idle());
    cmp("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_chkpt_table.md
Name: branch_chkpt_table

Overview:
- Parametrised, age-ordered checkpoint table for speculative branches. Successor to the fixed 4-slot snapshot store.
- Rename allocates one checkpoint per branch, carrying PC, ROB tag, PRF ready-table snapshot and an opaque payload (e.g. map table or free-list pointers).
- Correctly resolved branches release their entries in age order. A mispredict restores the matching snapshot and squashes all younger checkpoints.
- Sits between Rename/Dispatch (allocate), ROB/branch unit (resolve/mispredict) and PRF/RAT (restore).

Parameters:
- NUM_CHKPT, 4, number of entries; must be a power of 2, at least 2.
- ROB_TAG_W, 5, ROB tag width.
- PC_W, 32, PC width.
- PRF_SIZE, 128, ready-table snapshot width (one bit per physical register).
- PAYLOAD_W, 64, opaque extra snapshot bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- alloc_valid  in  1  new branch renamed this cycle
- alloc_pc  in  PC_W  branch PC
- alloc_rob_tag  in  ROB_TAG_W  branch ROB tag
- alloc_rdy  in  PRF_SIZE  ready-table snapshot
- alloc_payload  in  PAYLOAD_W  extra snapshot data
- alloc_ready  out  1  not full; rename must stall when low
- resolve_valid  in  1  branch resolved correctly
- resolve_tag  in  ROB_TAG_W  tag of the resolved branch
- mispredict  in  1  branch mispredicted
- mispredict_tag  in  ROB_TAG_W  tag of the mispredicted branch
- restore_valid  out  1  restore data valid (one-cycle pulse)
- restore_pc  out  PC_W  PC of the mispredicted branch
- restore_rdy  out  PRF_SIZE  ready-table snapshot
- restore_payload  out  PAYLOAD_W  extra snapshot data
- restore_miss  out  1  pulse: mispredict tag not found
- count  out  $clog2(NUM_CHKPT)+1  number of live entries
- alloc_overflow  out  1  sticky: alloc_valid seen while full

Behaviour:
- Storage: circular buffer. head = oldest entry, tail = next free slot. Both pointers are $clog2(NUM_CHKPT)+1 bits wide, with the extra bit as the wrap bit.
  - full when the index bits are equal and the wrap bits differ; empty when the pointers are equal.
  - Per-entry fields: valid, done, pc, rob_tag, rdy, payload.
- Reset: head=tail=0; all valid/done bits cleared; every output 0; alloc_ready=1.
- Alloc (alloc_valid && !full):
  - Write the entry at tail, set valid=1 and done=0, advance tail. Visible from the next cycle.
  - alloc_valid while full: entry dropped, alloc_overflow set (sticky until reset).
- Resolve:
  - CAM search over valid, not-done entries on resolve_tag; the single hit gets done=1.
  - No hit: ignored (the entry was already squashed).
- Retire: each cycle, if the head entry has valid && done, clear it and advance head. At most one retire per cycle.
- Mispredict:
  - CAM search over valid entries on mispredict_tag.
  - On a hit at index h: restore_* is registered, so restore_valid pulses 1 cycle later with the entry's contents. Entry h and every entry younger than it (the age range h..tail-1) are cleared, and tail = h with the wrap bit adjusted.
  - No hit: restore_miss pulses 1 cycle later; table unchanged.
- Priority within one cycle:
  - mispredict with a hit drops that cycle's alloc; alloc_overflow is not set.
  - resolve and retire still apply to entries older than h.
  - If retire hits entry h in the same cycle, mispredict wins and head does not advance past h.
  - alloc with a retire while full: alloc is refused. Full is evaluated on pre-update state.
- count = tail - head, computed combinationally from the registered pointers.
- alloc_ready = !full, combinational from registered state.
- Reset asserted mid-operation: all state and pending restore pulses cleared on the next edge.
- Duplicate tags among live entries: illegal, behaviour unspecified; a simulation assertion checks for this.

Optional Feature:
- CHKPT_PERF_EN defined: three 32-bit saturating counters with output ports perf_allocs, perf_restores, perf_full_stalls.
  - perf_full_stalls counts cycles with alloc_valid && full.
  - All counters cleared on reset.
- Not defined: the ports and counters are absent; functional behaviour is identical.

Decomposition:
- types_pkg: add typedef chkpt_entry_t (valid, done, pc, rob_tag, rdy, payload) and constant CHKPT_PTR_W.
- One sub-module, chkpt_cam: a combinational tag match that returns hit and one-hot index. Instantiated twice, for resolve and for mispredict.

Test Plan:
- Reset, then allocate 4 branches with tags 3,7,9,12 -> count=4, alloc_ready=0. A 5th alloc sets alloc_overflow=1 and the table is unchanged.
- Resolve tags 7 and 3 in that order -> no retire after 7; after 3, head retires entry 3 then entry 7 on consecutive cycles; count goes 4 -> 3 -> 2.
- With tags 3,7,9,12 live, mispredict tag 7 -> next cycle restore_valid=1, restore_pc and restore_rdy match the tag-7 alloc; count=1 (tag 3 only); tail index=1.
- Fill to tail wrap, then mispredict on the oldest entry -> count=0, alloc_ready=1; a new alloc lands at the correct wrapped index.
- Mispredict tag 20 (not present) -> restore_miss pulses, restore_valid=0, count unchanged.
- Same cycle: alloc tag 15 + mispredict tag 9 + resolve tag 3 -> tag 15 dropped; tags 9 and 12 squashed; tag 3 marked done and retired on the following cycle.
